// File: rtl/up_dn_pkg.sv
// Shared definitions for the up/down counter command path.
// Used by the command generator and by the counter it drives.
package up_dn_pkg;

    localparam int VAL_W = 5;

    typedef logic [VAL_W-1:0] val_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } rep_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter-based debouncer and registered rise detector
// for a single raw pushbutton.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_d;

    // A level change is accepted only after DB_CYCLES consecutive differing samples;
    // the counter clears on acceptance or on any agreeing sample, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            rise    <= level & ~level_d;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/up_dn_cmd_gen.sv
// Turns raw Load/Up/Down pushbuttons and SW switches into arbitrated,
// single-cycle, registered commands for a 5-bit up/down counter.
module up_dn_cmd_gen
    import up_dn_pkg::*;
#(
    parameter int DB_CYCLES  = 4,
    parameter int REP_DELAY  = 16,
    parameter int REP_PERIOD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Load_Btn,
    input  logic             Up_Btn,
    input  logic             Down_Btn,
    input  logic [VAL_W-1:0] SW,
    input  logic             High,
    input  logic             Low,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic [VAL_W-1:0] IN
);

    localparam int DW = (REP_DELAY > 0) ? $clog2(REP_DELAY + 1) : 1;
    localparam int PW = (REP_PERIOD > 1) ? $clog2(REP_PERIOD) : 1;

    logic       load_level;
    logic       load_rise;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] rep_req;
    val_t       sw_s1;
    val_t       sw_s2;
    logic       load_req;
    logic       up_ok;
    logic       down_ok;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
        .clk   (CLK),
        .rst_n (RST),
        .btn   (Load_Btn),
        .level (load_level),
        .rise  (load_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_up_db (
        .clk   (CLK),
        .rst_n (RST),
        .btn   (Up_Btn),
        .level (btn_level[0]),
        .rise  (btn_rise[0])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_down_db (
        .clk   (CLK),
        .rst_n (RST),
        .btn   (Down_Btn),
        .level (btn_level[1]),
        .rise  (btn_rise[1])
    );

    // Index 0 is the Up repeater, index 1 the Down repeater.
    for (genvar g = 0; g < 2; g++) begin : g_rep
        rep_state_t    state;
        rep_state_t    state_nxt;
        logic [DW-1:0] dly;
        logic [DW-1:0] dly_nxt;
        logic [PW-1:0] per;
        logic [PW-1:0] per_nxt;
        logic          req;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                state <= ST_IDLE;
                dly   <= '0;
                per   <= '0;
            end else begin
                state <= state_nxt;
                dly   <= dly_nxt;
                per   <= per_nxt;
            end
        end

        // dly counts cycles since the initial pulse and saturates at REP_DELAY;
        // per reloads to zero after each repeat slot.
        always_comb begin
            state_nxt = state;
            dly_nxt   = dly;
            per_nxt   = per;
            req       = 1'b0;
            if (!btn_level[g]) begin
                state_nxt = ST_IDLE;
                dly_nxt   = '0;
                per_nxt   = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (btn_rise[g]) begin
                            req       = 1'b1;
                            state_nxt = ST_PRESS;
                            dly_nxt   = DW'(1);
                        end
                    end
                    ST_PRESS: begin
                        state_nxt = ST_HOLD;
                        dly_nxt   = (dly >= DW'(REP_DELAY)) ? dly : dly + 1'b1;
                    end
                    ST_HOLD: begin
                        if (dly >= DW'(REP_DELAY)) begin
                            state_nxt = ST_REPEAT;
                            per_nxt   = '0;
                        end else begin
                            dly_nxt = dly + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        req     = (per == '0);
                        per_nxt = (per == PW'(REP_PERIOD - 1)) ? '0 : per + 1'b1;
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end

        assign rep_req[g] = req;
    end

    // Load beats Down beats Up; a held Down button also locks out Up entirely.
    assign load_req = load_rise & load_level;
    assign down_ok  = rep_req[1] & ~Low;
    assign up_ok    = rep_req[0] & ~High & ~btn_level[1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            Load  <= 1'b0;
            Up    <= 1'b0;
            Down  <= 1'b0;
            IN    <= '0;
        end else begin
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
            Load  <= load_req;
            Down  <= down_ok & ~load_req;
            Up    <= up_ok & ~load_req & ~down_ok;
            if (load_req) begin
                IN <= sw_s2;
            end
        end
    end

endmodule

// File: tb/tb_up_dn_cmd_gen.sv
// Scoreboard bench for up_dn_cmd_gen: directed button sequences push the
// hand-derived pulse schedule, a negedge monitor pops and compares.
module tb_up_dn_cmd_gen;
    import up_dn_pkg::*;

    localparam int DB = 4;
    localparam int RD = 16;
    localparam int RP = 4;

    localparam logic [2:0] K_LOAD = 3'b100;
    localparam logic [2:0] K_UP   = 3'b010;
    localparam logic [2:0] K_DOWN = 3'b001;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        val_t       val;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic Load_Btn = 1'b0;
    logic Up_Btn = 1'b0;
    logic Down_Btn = 1'b0;
    logic High = 1'b0;
    logic Low = 1'b0;
    val_t SW = '0;
    logic Load;
    logic Up;
    logic Down;
    val_t IN;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t       mon_e;
    logic [2:0] mon_got;

    up_dn_cmd_gen #(
        .DB_CYCLES  (DB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Load_Btn (Load_Btn),
        .Up_Btn   (Up_Btn),
        .Down_Btn (Down_Btn),
        .SW       (SW),
        .High     (High),
        .Low      (Low),
        .Load     (Load),
        .Up       (Up),
        .Down     (Down),
        .IN       (IN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Any command pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST && (Load || Up || Down)) begin
            mon_got = {Load, Up, Down};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: got {Load,Up,Down}=%b at cycle %0d, required no pulse",
                         mon_got, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_got !== mon_e.kind || cyc != mon_e.cyc ||
                    (mon_e.kind == K_LOAD && IN !== mon_e.val)) begin
                    errors++;
                    $display("[TB] FAIL pulse: got {Load,Up,Down}=%b cycle=%0d IN=%0d, required %b cycle=%0d IN=%0d",
                             mon_got, cyc, IN, mon_e.kind, mon_e.cyc, mon_e.val);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic drain_check(input string name);
        wait_cyc(20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: got %0d pulses still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Button driven high at negedge c and low at negedge r: first pulse DB+4 later,
    // repeats from RD+1 after that every RP, last possible one DB+2 after release.
    task automatic push_held(input logic [2:0] kind, input int c, input int r, input int lo);
        int f;
        int hi;
        int p;
        f  = c + DB + 4;
        hi = r + DB + 2;
        if (f >= lo && f <= hi) sb.push_back('{f, kind, 5'd0});
        p = f + RD + 1;
        while (p <= hi) begin
            if (p >= lo) sb.push_back('{p, kind, 5'd0});
            p += RP;
        end
    endtask

    task automatic apply_stimulus();
        int c;
        int h;
        int q;

        wait_cyc(3);
        check_output("reset_load", 32'(Load), 0);
        check_output("reset_up", 32'(Up), 0);
        check_output("reset_down", 32'(Down), 0);
        check_output("reset_in", 32'(IN), 0);
        RST = 1'b1;
        wait_cyc(5);

        $display("[TB] bouncing Up press");
        for (int i = 0; i < 4; i++) begin
            Up_Btn = ~i[0];
            wait_cyc(1);
        end
        Up_Btn = 1'b1;
        c = cyc;
        push_held(K_UP, c, c + 10, 0);
        wait_cyc(10);
        Up_Btn = 1'b0;
        drain_check("bounce_single_pulse");

        $display("[TB] Down held 40 cycles");
        c = cyc;
        Down_Btn = 1'b1;
        push_held(K_DOWN, c, c + 40, 0);
        wait_cyc(40);
        Down_Btn = 1'b0;
        drain_check("down_repeat");

        $display("[TB] Load with Up, SW=19");
        SW = 5'd19;
        wait_cyc(3);
        c = cyc;
        Load_Btn = 1'b1;
        Up_Btn = 1'b1;
        sb.push_back('{c + DB + 4, K_LOAD, 5'd19});
        wait_cyc(10);
        Load_Btn = 1'b0;
        Up_Btn = 1'b0;
        drain_check("load_priority");
        SW = 5'd7;
        wait_cyc(5);
        check_output("in_hold", 32'(IN), 19);

        $display("[TB] Up held with High, High drops mid-repeat");
        High = 1'b1;
        c = cyc;
        Up_Btn = 1'b1;
        wait_cyc(31);
        High = 1'b0;
        h = cyc;
        push_held(K_UP, c, c + 40, h + 1);
        wait_cyc(9);
        Up_Btn = 1'b0;
        drain_check("high_suppress");

        $display("[TB] Down held with Low");
        Low = 1'b1;
        Down_Btn = 1'b1;
        wait_cyc(12);
        Down_Btn = 1'b0;
        drain_check("low_suppress");
        Low = 1'b0;

        $display("[TB] Up and Down held together");
        c = cyc;
        Up_Btn = 1'b1;
        Down_Btn = 1'b1;
        push_held(K_DOWN, c, c + 30, 0);
        push_held(K_UP, c, c + 38, c + 37);
        wait_cyc(30);
        Down_Btn = 1'b0;
        wait_cyc(8);
        Up_Btn = 1'b0;
        drain_check("down_over_up");

        $display("[TB] reset during Up repeat");
        c = cyc;
        Up_Btn = 1'b1;
        push_held(K_UP, c, c + 23, 0);
        wait_cyc(29);
        #2 RST = 1'b0;
        #1;
        check_output("rst_up", 32'(Up), 0);
        check_output("rst_load", 32'(Load), 0);
        check_output("rst_down", 32'(Down), 0);
        check_output("rst_in", 32'(IN), 0);
        wait_cyc(4);
        RST = 1'b1;
        q = cyc;
        push_held(K_UP, q, q + 10, 0);
        wait_cyc(10);
        Up_Btn = 1'b0;
        drain_check("reset_fresh_press");
    endtask

    initial begin
        apply_stimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
